// File: rtl/vga_fb_pkg.sv
// Shared constants and the memory request bundle for the framebuffer scheduler.
package vga_fb_pkg;

    localparam int FB_WORDS_C   = 76800;
    localparam int LINE_WORDS_C = 160;
    localparam int FB_AW        = 17;
    localparam int PIX_W        = 8;

    typedef struct packed {
        logic             en;
        logic             we;
        logic [FB_AW-1:0] addr;
        logic [31:0]      wdata;
        logic [3:0]       wmask;
    } mem_req_t;

endpackage

// File: rtl/vga_word_fifo.sv
// Synchronous word FIFO with flush and combinational head. Push or pop takes effect on the edge.
// No internal backpressure: the caller never pushes when full nor pops when empty.
module vga_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                   pclk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_dat,
    input  logic                   pop,
    output logic [W-1:0]           head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (push && !flush) store[wr_ptr] <= push_dat;
    end

    assign head_dat = store[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/vga_fb_sched.sv
// Display prefetch wins the memory only while urgent, CPU writes take the rest; read->FIFO 1 cycle, cpu_ready low only when urgent.
// Defining VGA_FB_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module vga_fb_sched
    import vga_fb_pkg::*;
#(
    parameter int FB_WORDS     = FB_WORDS_C,
    parameter int FIFO_DEPTH   = 4,
    parameter int URGENT_LEVEL = 2
) (
    input  logic             pclk,
    input  logic             reset,
    input  logic [9:0]       h_addr,
    input  logic             valid,
    input  logic             vsync,
    output logic [PIX_W-1:0] vga_data,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic [FB_AW-1:0] cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_wmask,
    output logic             mem_en,
    output logic             mem_we,
    output logic [FB_AW-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wmask,
    input  logic [31:0]      mem_rdata,
`ifdef VGA_FB_UNDERRUN_CNT_EN
    output logic             underrun,
    output logic [15:0]      underrun_cnt
`else
    output logic             underrun
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    typedef logic [CW:0] lvl_t;
    localparam logic [FB_AW-1:0] FB_END   = FB_AW'(FB_WORDS);
    localparam lvl_t             URG_LVL  = lvl_t'(URGENT_LEVEL);
    localparam lvl_t             FULL_LVL = lvl_t'(FIFO_DEPTH);

    logic [FB_AW-1:0] fptr;
    logic             rd_inflight;
    logic [CW-1:0]    fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [31:0]      fifo_head;
    lvl_t             level;
    logic             fetch_done;
    logic             urgent;
    logic             fetch;
    logic             cpu_take;
    mem_req_t         mem_req;
    logic             unused_h;

    assign unused_h = ^h_addr[9:2];

    // In-flight read counts toward the level so the FIFO can never be over-committed.
    assign level      = lvl_t'(fifo_count) + lvl_t'(rd_inflight);
    assign fetch_done = (fptr == FB_END);
    assign urgent     = !reset && vsync && !fetch_done && (level < URG_LVL);
    assign cpu_ready  = !urgent || !vsync;

    always_comb begin
        mem_req  = '0;
        fetch    = 1'b0;
        cpu_take = 1'b0;
        if (!reset) begin
            if (urgent)
                fetch = 1'b1;
            else if (cpu_valid)
                cpu_take = 1'b1;
            else if (vsync && !fetch_done && (level < FULL_LVL))
                fetch = 1'b1;
        end
        if (fetch) begin
            mem_req.en   = 1'b1;
            mem_req.addr = fptr;
        end else if (cpu_take && (cpu_addr < FB_END)) begin
            mem_req.en    = 1'b1;
            mem_req.we    = 1'b1;
            mem_req.addr  = cpu_addr;
            mem_req.wdata = cpu_wdata;
            mem_req.wmask = cpu_wmask;
        end
    end

    assign mem_en    = mem_req.en;
    assign mem_we    = mem_req.we;
    assign mem_addr  = mem_req.addr;
    assign mem_wdata = mem_req.wdata;
    assign mem_wmask = mem_req.wmask;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            fptr        <= '0;
            rd_inflight <= 1'b0;
            underrun    <= 1'b0;
        end else if (!vsync) begin
            fptr        <= '0;
            rd_inflight <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            rd_inflight <= fetch;
            if (fetch) fptr <= fptr + 1'b1;
            if (valid && fifo_empty) underrun <= 1'b1;
        end
    end

    assign fifo_push = rd_inflight && vsync;
    assign fifo_pop  = vsync && valid && (h_addr[1:0] == 2'd3) && !fifo_empty;

    vga_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .pclk     (pclk),
        .reset    (reset),
        .flush    (!vsync),
        .push     (fifo_push),
        .push_dat (mem_rdata),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // Byte 0 of a word is the leftmost of its four pixels.
    assign vga_data = fifo_empty ? '0 : fifo_head[{h_addr[1:0], 3'b000} +: PIX_W];

`ifdef VGA_FB_UNDERRUN_CNT_EN
    always_ff @(posedge pclk or posedge reset) begin
        if (reset)
            underrun_cnt <= '0;
        else if (valid && fifo_empty && (underrun_cnt != 16'hFFFF))
            underrun_cnt <= underrun_cnt + 16'd1;
    end
`endif

endmodule
